// File: rtl/add_seq64_pkg.sv
// Shared definitions for the 64-bit add/subtract sequencer.
// The FSM encodings and widths live here so that the top and the bench agree.
package add_seq64_pkg;

  // Adder slice width and full operation width.
  localparam int SLICE_W = 32;
  localparam int DW      = 64;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  // Conditionally invert an adder operand (B for subtract).
  function automatic logic [SLICE_W-1:0] cond_invert(input logic [SLICE_W-1:0] v,
                                                     input logic               inv);
    return v ^ {SLICE_W{inv}};
  endfunction

endpackage

// File: rtl/add_all.sv
// Existing N-bit ripple-carry adder.
// cout is the carry out of the most significant bit position (C[N]),
// so it can be chained directly into the next slice.
module add_all #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c,
  output logic [N-1:0] sum,
  output logic         cout
);

  // Bit-serial ripple: generate/propagate per bit, carry rippled through a local.
  always_comb begin
    logic carry_v;
    carry_v = c;
    sum     = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      sum[i]  = a[i] ^ b[i] ^ carry_v;
      carry_v = (a[i] & b[i]) | ((a[i] ^ b[i]) & carry_v);
    end
    cout = carry_v;
  end

endmodule

// File: rtl/add_seq64.sv
// 64-bit add/subtract sequencer built on one time-shared 32-bit adder.
// Low word is computed first, then the high word with the low carry chained in.
// Subtract is A + ~B + 1. Optional signed-overflow output: define ADD_SEQ_OVF_EN.
module add_seq64
  import add_seq64_pkg::*;
#(
  parameter int W = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_a,
  input  logic [DW-1:0] in_b,
  input  logic          in_sub,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_sum,
  output logic          out_cout
`ifdef ADD_SEQ_OVF_EN
  , output logic        out_ovf
`endif
);

  state_t         state_r;
  logic [DW-1:0]  a_r;
  logic [DW-1:0]  b_r;
  logic           sub_r;
  logic           carry_r;

  logic [W-1:0]   add_a_s;
  logic [W-1:0]   add_b_s;
  logic           add_c_s;
  logic [W-1:0]   add_sum_s;
  logic           add_cout_s;

  // Select the adder operands for the current beat: high word in HI, low word otherwise.
  always_comb begin
    add_a_s = a_r[W-1:0];
    add_b_s = cond_invert(b_r[W-1:0], sub_r);
    add_c_s = sub_r;
    if (state_r == HI) begin
      add_a_s = a_r[DW-1:W];
      add_b_s = cond_invert(b_r[DW-1:W], sub_r);
      add_c_s = carry_r;
    end else begin
      add_a_s = a_r[W-1:0];
      add_b_s = cond_invert(b_r[W-1:0], sub_r);
      add_c_s = sub_r;
    end
  end

  add_all #(
    .N(W)
  ) u_add (
    .a    (add_a_s),
    .b    (add_b_s),
    .c    (add_c_s),
    .sum  (add_sum_s),
    .cout (add_cout_s)
  );

`ifdef ADD_SEQ_OVF_EN
  logic bx_top_s;
  logic ovf_s;

  // Signed overflow: operands share a sign and the result sign differs.
  always_comb begin
    bx_top_s = b_r[DW-1] ^ sub_r;
    if ((a_r[DW-1] == bx_top_s) && (add_sum_s[W-1] != a_r[DW-1])) begin
      ovf_s = 1'b1;
    end else begin
      ovf_s = 1'b0;
    end
  end
`endif

  // Sequencer FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_sum   <= {DW{1'b0}};
      out_cout  <= 1'b0;
      a_r       <= {DW{1'b0}};
      b_r       <= {DW{1'b0}};
      sub_r     <= 1'b0;
      carry_r   <= 1'b0;
`ifdef ADD_SEQ_OVF_EN
      out_ovf   <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_r      <= in_a;
            b_r      <= in_b;
            sub_r    <= in_sub;
            in_ready <= 1'b0;
            state_r  <= LO;
          end else begin
            state_r  <= IDLE;
          end
        end
        LO: begin
          out_sum[W-1:0] <= add_sum_s;
          carry_r        <= add_cout_s;
          state_r        <= HI;
        end
        HI: begin
          out_sum[DW-1:W] <= add_sum_s;
          out_cout        <= add_cout_s;
`ifdef ADD_SEQ_OVF_EN
          out_ovf         <= ovf_s;
`endif
          out_valid       <= 1'b1;
          state_r         <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_r   <= IDLE;
          end else begin
            state_r   <= DONE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_add_seq64.sv
// Self-checking bench for add_seq64: reset, arithmetic table, backpressure,
// reset in the middle of an operation. Expected results come from a 65-bit model.
module tb_add_seq64;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic        in_sub;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_sum;
  logic        out_cout;
`ifdef ADD_SEQ_OVF_EN
  logic        out_ovf;
`endif

  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  res_t sb_q[$];
  int   check_cnt = 0;
  int   pass_cnt  = 0;

  add_seq64 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout)
`ifdef ADD_SEQ_OVF_EN
    , .out_ovf (out_ovf)
`endif
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [63:0] a, input logic [63:0] b, input logic s);
    res_t        r;
    logic [63:0] bx;
    logic [64:0] t;
    bx     = s ? ~b : b;
    t      = {1'b0, a} + {1'b0, bx} + {64'd0, s};
    r.sum  = t[63:0];
    r.cout = t[64];
    r.ovf  = (a[63] == bx[63]) && (t[63] != a[63]);
    return r;
  endfunction

  // Present an op from a negedge; returns at the negedge after the accepting edge.
  task automatic drive_op(input logic [63:0] a, input logic [63:0] b, input logic s,
                          output bit ok);
    bit rdy;
    in_a = a; in_b = b; in_sub = s; in_valid = 1'b1; ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      rdy = in_ready;
      @(posedge clk);
      if (rdy) ok = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!ok) begin
      check_cnt++;
      $display("FAIL accept_timeout: in_ready never seen high within 20 cycles");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_a = 64'h1; in_b = 64'h2; in_sub = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    check_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b want 1", in_ready); else pass_cnt++;
    check_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b want 0", out_valid); else pass_cnt++;
    check_cnt++; if (out_sum !== 64'h0) $display("FAIL reset_out_sum got %h want 0", out_sum); else pass_cnt++;
    check_cnt++; if (out_cout !== 1'b0) $display("FAIL reset_out_cout got %0b want 0", out_cout); else pass_cnt++;
`ifdef ADD_SEQ_OVF_EN
    check_cnt++; if (out_ovf !== 1'b0) $display("FAIL reset_out_ovf got %0b want 0", out_ovf); else pass_cnt++;
`endif
    @(negedge clk);
    check_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_nolatch in_ready got %0b want 1", in_ready); else pass_cnt++;
  endtask

  task automatic test_arith();
    logic [63:0] va[10];
    logic [63:0] vb[10];
    logic        vs[10];
    res_t        e;
    bit          ok;
    va[0] = 64'h0000_0000_FFFF_FFFF; vb[0] = 64'h1; vs[0] = 1'b0;
    va[1] = 64'hFFFF_FFFF_FFFF_FFFF; vb[1] = 64'h1; vs[1] = 1'b0;
    va[2] = 64'h5;                   vb[2] = 64'h7; vs[2] = 1'b1;
    va[3] = 64'h7;                   vb[3] = 64'h5; vs[3] = 1'b1;
    va[4] = 64'h7FFF_FFFF_FFFF_FFFF; vb[4] = 64'h1; vs[4] = 1'b0;
    va[5] = 64'h8000_0000_0000_0000; vb[5] = 64'h1; vs[5] = 1'b1;
    for (int i = 6; i < 10; i++) begin
      va[i] = {$urandom, $urandom};
      vb[i] = {$urandom, $urandom};
      vs[i] = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < 10; i++) begin
      e = model(va[i], vb[i], vs[i]);
      drive_op(va[i], vb[i], vs[i], ok);
      if (ok) sb_q.push_back(e);
      @(negedge clk);
      check_cnt++; if (out_valid !== 1'b0) $display("FAIL arith%0d_early_valid got %0b want 0", i, out_valid); else pass_cnt++;
      @(negedge clk);
      check_cnt++; if (out_valid !== 1'b1) $display("FAIL arith%0d_valid got %0b want 1", i, out_valid); else pass_cnt++;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check_cnt++; if (out_sum !== e.sum) $display("FAIL arith%0d_sum got %h want %h", i, out_sum, e.sum); else pass_cnt++;
        check_cnt++; if (out_cout !== e.cout) $display("FAIL arith%0d_cout got %0b want %0b", i, out_cout, e.cout); else pass_cnt++;
`ifdef ADD_SEQ_OVF_EN
        check_cnt++; if (out_ovf !== e.ovf) $display("FAIL arith%0d_ovf got %0b want %0b", i, out_ovf, e.ovf); else pass_cnt++;
`endif
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
        $display("FAIL arith%0d_release valid=%0b ready=%0b want 0/1", i, out_valid, in_ready); else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    res_t e1;
    res_t e2;
    res_t e;
    bit   ok;
    e1 = model(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0);
    e2 = model(64'h0000_0001_0000_0000, 64'h0000_0000_0000_0001, 1'b1);
    drive_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, ok);
    if (ok) sb_q.push_back(e1);
    repeat (2) @(negedge clk);
    if (sb_q.size() != 0) e1 = sb_q.pop_front();
    in_a = 64'h0000_0001_0000_0000; in_b = 64'h1; in_sub = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_cnt++; if (out_valid !== 1'b1) $display("FAIL bp%0d_valid got %0b want 1", i, out_valid); else pass_cnt++;
      check_cnt++; if (in_ready !== 1'b0) $display("FAIL bp%0d_in_ready got %0b want 0", i, in_ready); else pass_cnt++;
      check_cnt++; if (out_sum !== e1.sum || out_cout !== e1.cout)
        $display("FAIL bp%0d_hold got %h/%0b want %h/%0b", i, out_sum, out_cout, e1.sum, e1.cout); else pass_cnt++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL bp_release valid=%0b ready=%0b want 0/1", out_valid, in_ready); else pass_cnt++;
    drive_op(64'h0000_0001_0000_0000, 64'h1, 1'b1, ok);
    if (ok) sb_q.push_back(e2);
    @(negedge clk);
    check_cnt++; if (out_valid !== 1'b0) $display("FAIL bp_op2_early_valid got %0b want 0", out_valid); else pass_cnt++;
    @(negedge clk);
    check_cnt++; if (out_valid !== 1'b1) $display("FAIL bp_op2_valid got %0b want 1", out_valid); else pass_cnt++;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check_cnt++; if (out_sum !== e.sum || out_cout !== e.cout)
        $display("FAIL bp_op2_result got %h/%0b want %h/%0b", out_sum, out_cout, e.sum, e.cout); else pass_cnt++;
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    res_t e;
    bit   ok;
    drive_op(64'hAAAA_AAAA_5555_5555, 64'h1111_1111_2222_2222, 1'b0, ok);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_cnt++; if (out_valid !== 1'b0) $display("FAIL rstmid_valid got %0b want 0", out_valid); else pass_cnt++;
    check_cnt++; if (in_ready !== 1'b1) $display("FAIL rstmid_in_ready got %0b want 1", in_ready); else pass_cnt++;
    check_cnt++; if (out_sum !== 64'h0 || out_cout !== 1'b0)
      $display("FAIL rstmid_outputs got %h/%0b want 0/0", out_sum, out_cout); else pass_cnt++;
    @(negedge clk);
    check_cnt++; if (out_valid !== 1'b0) $display("FAIL rstmid_no_partial got %0b want 0", out_valid); else pass_cnt++;
    e = model(64'hFFFF_FFFF_0000_0000, 64'h0000_0001_FFFF_FFFF, 1'b1);
    drive_op(64'hFFFF_FFFF_0000_0000, 64'h0000_0001_FFFF_FFFF, 1'b1, ok);
    if (ok) sb_q.push_back(e);
    repeat (2) @(negedge clk);
    check_cnt++; if (out_valid !== 1'b1) $display("FAIL rstmid_new_valid got %0b want 1", out_valid); else pass_cnt++;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check_cnt++; if (out_sum !== e.sum || out_cout !== e.cout)
        $display("FAIL rstmid_new_result got %h/%0b want %h/%0b", out_sum, out_cout, e.sum, e.cout); else pass_cnt++;
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = 64'h0; in_b = 64'h0; in_sub = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_arith();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit reached");
  end

endmodule
